// File: rtl/sw_adaptor_pkg.sv
// Shared definitions for the software adaptor request/response protocol.
// Used by both the adaptor and the host-side initiator.
//   PKT_S      : beat width on the adaptor data pins
//   D_S        : response payload width (RSP_BEATS beats)
//   KH_S       : key hash width (two beats)
//   DT_S       : request type width
//   init_state_t : initiator FSM states
//   make_header  : builds the request header beat from a request type
package sw_adaptor_pkg;

  localparam int PKT_S     = 32;
  localparam int D_S       = 128;
  localparam int KH_S      = 64;
  localparam int DT_S      = 3;
  localparam int REQ_BEATS = 4;
  localparam int RSP_BEATS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RECV = 2'd2,
    ST_DONE = 2'd3
  } init_state_t;

  // Header beat: request type zero-extended to the full beat width.
  function automatic logic [PKT_S-1:0] make_header(input logic [DT_S-1:0] req_type);
    logic [PKT_S-1:0] hdr;
    hdr             = '0;
    hdr[DT_S-1:0]   = req_type;
    return hdr;
  endfunction

endpackage

// File: rtl/sw_request_initiator.sv
// Host-side initiator for the software adaptor protocol.
// Accepts one command (type + key hash), serializes it into a four-beat
// request burst, holds rd_ready while collecting the four-beat response,
// then presents the assembled payload over a valid/ready handshake.
// All outputs are registered; reset is asynchronous, active-low.
// Ports:
//   clk, rst                      : clock, async active-low reset
//   cmd_valid/cmd_ready           : client command handshake
//   cmd_type, cmd_key             : request type and key hash
//   req_data, req_valid           : request beats to adaptor data_in
//   rd_ready                      : ready for response beats
//   rsp_data, rsp_valid           : response beats from adaptor
//   result_data/valid/ready       : assembled response handshake
//   timeout_err                   : one-cycle pulse on response timeout
//   busy                          : high in any state other than IDLE
module sw_request_initiator #(
  parameter int PKT_S   = sw_adaptor_pkg::PKT_S,
  parameter int D_S     = sw_adaptor_pkg::D_S,
  parameter int KH_S    = sw_adaptor_pkg::KH_S,
  parameter int DT_S    = sw_adaptor_pkg::DT_S,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [DT_S-1:0]  cmd_type,
  input  logic [KH_S-1:0]  cmd_key,
  output logic [PKT_S-1:0] req_data,
  output logic             req_valid,
  output logic             rd_ready,
  input  logic [PKT_S-1:0] rsp_data,
  input  logic             rsp_valid,
  output logic [D_S-1:0]   result_data,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             timeout_err,
  output logic             busy
);

  import sw_adaptor_pkg::*;

  localparam int          TO_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0]  LAST_REQ = 2'(REQ_BEATS - 1);
  localparam logic [1:0]  LAST_RSP = 2'(RSP_BEATS - 1);
  // Threshold on the counter value before increment: the idle cycle that
  // would take the counter to TIMEOUT-1 is the one that times out.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 2);

  // Request beat for a given index: header, type, key high, key low.
  function automatic logic [PKT_S-1:0] req_beat(input logic [1:0]      idx,
                                                input logic [DT_S-1:0] t,
                                                input logic [KH_S-1:0] k);
    logic [PKT_S-1:0] beat;
    case (idx)
      2'd0, 2'd1: beat = make_header(t);
      2'd2:       beat = k[KH_S-1 -: PKT_S];
      default:    beat = k[PKT_S-1:0];
    endcase
    return beat;
  endfunction

  init_state_t      r_state, w_state_nxt;
  logic [1:0]       r_cnt, w_cnt_nxt;
  logic [TO_W-1:0]  r_to_cnt, w_to_nxt;
  logic [DT_S-1:0]  r_type, w_type_nxt;
  logic [KH_S-1:0]  r_key, w_key_nxt;
  logic [D_S-1:0]   r_result, w_result_nxt;
  logic             r_cmd_ready, w_cmd_ready_nxt;
  logic [PKT_S-1:0] r_req_data, w_req_data_nxt;
  logic             r_req_valid, w_req_valid_nxt;
  logic             r_rd_ready, w_rd_ready_nxt;
  logic             r_result_valid, w_result_valid_nxt;
  logic             r_timeout_err, w_timeout_nxt;
  logic             r_busy, w_busy_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_to_cnt       <= '0;
      r_type         <= '0;
      r_key          <= '0;
      r_result       <= '0;
      r_cmd_ready    <= 1'b0;
      r_req_data     <= '0;
      r_req_valid    <= 1'b0;
      r_rd_ready     <= 1'b0;
      r_result_valid <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_to_cnt       <= w_to_nxt;
      r_type         <= w_type_nxt;
      r_key          <= w_key_nxt;
      r_result       <= w_result_nxt;
      r_cmd_ready    <= w_cmd_ready_nxt;
      r_req_data     <= w_req_data_nxt;
      r_req_valid    <= w_req_valid_nxt;
      r_rd_ready     <= w_rd_ready_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_timeout_err  <= w_timeout_nxt;
      r_busy         <= w_busy_nxt;
    end
  end

  // Next-state and next-output logic. Outputs are computed for the state
  // being entered so that every output comes straight from a flop.
  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_to_nxt           = r_to_cnt;
    w_type_nxt         = r_type;
    w_key_nxt          = r_key;
    w_result_nxt       = r_result;
    w_req_data_nxt     = '0;
    w_req_valid_nxt    = 1'b0;
    w_rd_ready_nxt     = 1'b0;
    w_result_valid_nxt = 1'b0;
    w_timeout_nxt      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_state_nxt     = ST_SEND;
          w_type_nxt      = cmd_type;
          w_key_nxt       = cmd_key;
          w_cnt_nxt       = 2'd0;
          w_to_nxt        = '0;
          w_result_nxt    = '0;
          w_req_valid_nxt = 1'b1;
          w_req_data_nxt  = req_beat(2'd0, cmd_type, cmd_key);
        end
      end

      ST_SEND: begin
        if (r_cnt == LAST_REQ) begin
          w_state_nxt    = ST_RECV;
          w_cnt_nxt      = 2'd0;
          w_to_nxt       = '0;
          w_rd_ready_nxt = 1'b1;
        end else begin
          w_cnt_nxt       = r_cnt + 2'd1;
          w_req_valid_nxt = 1'b1;
          w_req_data_nxt  = req_beat(r_cnt + 2'd1, r_type, r_key);
        end
      end

      ST_RECV: begin
        // A beat arriving on the threshold cycle wins over the timeout.
        if (rsp_valid) begin
          w_result_nxt[int'(r_cnt)*PKT_S +: PKT_S] = rsp_data;
          w_to_nxt = '0;
          if (r_cnt == LAST_RSP) begin
            w_state_nxt        = ST_DONE;
            w_cnt_nxt          = 2'd0;
            w_result_valid_nxt = 1'b1;
          end else begin
            w_cnt_nxt      = r_cnt + 2'd1;
            w_rd_ready_nxt = 1'b1;
          end
        end else if (r_to_cnt == TO_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_cnt_nxt     = 2'd0;
          w_to_nxt      = '0;
          w_result_nxt  = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_to_nxt       = r_to_cnt + TO_W'(1);
          w_rd_ready_nxt = 1'b1;
        end
      end

      ST_DONE: begin
        if (result_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_result_valid_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
  end

  assign cmd_ready    = r_cmd_ready;
  assign req_data     = r_req_data;
  assign req_valid    = r_req_valid;
  assign rd_ready     = r_rd_ready;
  assign result_data  = r_result;
  assign result_valid = r_result_valid;
  assign timeout_err  = r_timeout_err;
  assign busy         = r_busy;

endmodule

// File: tb/tb_sw_request_initiator.sv
module tb_sw_request_initiator;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_type;
  logic [63:0]  cmd_key;
  logic [31:0]  req_data;
  logic         req_valid;
  logic         rd_ready;
  logic [31:0]  rsp_data;
  logic         rsp_valid;
  logic [127:0] result_data;
  logic         result_valid;
  logic         result_ready;
  logic         timeout_err;
  logic         busy;

  int n_tests  = 0;
  int n_fail   = 0;
  int te_count = 0;

  always #5 clk = ~clk;

  sw_request_initiator #(
    .PKT_S(32), .D_S(128), .KH_S(64), .DT_S(3), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_key(cmd_key),
    .req_data(req_data), .req_valid(req_valid),
    .rd_ready(rd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .result_data(result_data), .result_valid(result_valid),
    .result_ready(result_ready),
    .timeout_err(timeout_err), .busy(busy)
  );

  always @(negedge clk) if (timeout_err === 1'b1) te_count++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_beat(input int i, input logic [2:0] t, input logic [63:0] k);
    case (i)
      0, 1:    return {29'd0, t};
      2:       return k[63:32];
      default: return k[31:0];
    endcase
  endfunction

  task automatic accept_cmd(input logic [2:0] t, input logic [63:0] k);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_val("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_key   = k;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Called right after the accept edge: checks the four request beats and
  // the switch to response collection.
  task automatic run_send(input logic [2:0] t, input logic [63:0] k);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("req_valid_b%0d", i), req_valid, 1);
      check_val($sformatf("req_data_b%0d", i), req_data, exp_beat(i, t, k));
      tick();
    end
    check_val("req_valid_off", req_valid, 0);
    check_val("req_data_off", req_data, 0);
    check_val("rd_ready_on", rd_ready, 1);
  endtask

  task automatic do_response(input logic [127:0] d, input int g0, input int g);
    for (int i = 0; i < 4; i++) begin
      int gap;
      gap = (i == 0) ? g0 : g;
      for (int j = 0; j < gap; j++) begin
        rsp_valid = 1'b0;
        check_val("rd_ready_held", rd_ready, 1);
        tick();
      end
      check_val("rd_ready_beat", rd_ready, 1);
      rsp_valid = 1'b1;
      rsp_data  = d[i*32 +: 32];
      tick();
      if (i < 3) check_val("result_early", result_valid, 0);
    end
    rsp_valid = 1'b0;
    rsp_data  = '0;
    check_val("result_valid", result_valid, 1);
    check_val("result_data", result_data, d);
  endtask

  initial begin
    logic [127:0] d1, d2, d5, d6, held;
    logic [63:0]  k1, k2, k5, k6;
    int te_before;

    d1 = 128'hDEADBEEF_CAFEF00D_12345678_00000001;
    d2 = 128'h44444444_33333333_22222222_11111111;
    d5 = 128'h0BADF00D_FEEDFACE_87654321_A5A5A5A5;
    d6 = 128'h13579BDF_2468ACE0_FFFF0000_0000FFFF;
    k1 = 64'h0123_4567_89AB_CDEF;
    k2 = 64'hFEDC_BA98_7654_3210;
    k5 = 64'hAAAA_5555_0F0F_F0F0;
    k6 = 64'h1111_2222_3333_4444;

    rst = 1'b0; cmd_valid = 1'b0; cmd_type = '0; cmd_key = '0;
    rsp_data = '0; rsp_valid = 1'b0; result_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_outputs",
              {cmd_ready, req_valid, rd_ready, result_valid, timeout_err, busy}, 6'd0);
    check_val("rst_req_data", req_data, 0);
    check_val("rst_result", result_data, 0);
    #2 rst = 1'b1;
    #1 check_val("cmd_ready_pre", cmd_ready, 0);
    tick();
    check_val("cmd_ready_rise", cmd_ready, 1);

    // Basic transaction, zero-wait responder
    accept_cmd(3'b101, k1);
    check_val("cmd_ready_drop", cmd_ready, 0);
    check_val("busy_send", busy, 1);
    run_send(3'b101, k1);
    te_before = te_count;
    do_response(d1, 0, 0);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check_val("hs_result_valid", result_valid, 0);
    check_val("hs_cmd_ready", cmd_ready, 1);
    check_val("hs_busy", busy, 0);

    // Three-cycle gap before every response beat
    accept_cmd(3'b010, k2);
    run_send(3'b010, k2);
    do_response(d2, 3, 3);
    check_val("gap_no_timeout", te_count, te_before);

    // Result held 10 cycles; command and stray response beats ignored
    held = result_data;
    cmd_valid = 1'b1; cmd_type = 3'b011; cmd_key = k6;
    rsp_valid = 1'b1; rsp_data = 32'h5A5A_5A5A;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("hold_valid", result_valid, 1);
      check_val("hold_data", result_data, held);
      check_val("hold_cmd_ready", cmd_ready, 0);
      check_val("hold_req_valid", req_valid, 0);
    end
    rsp_valid = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check_val("hold_hs_valid", result_valid, 0);
    check_val("hold_hs_cmd_ready", cmd_ready, 1);
    check_val("hold_hs_req_valid", req_valid, 0);
    tick();
    cmd_valid = 1'b0;
    check_val("resume_req_valid", req_valid, 1);
    check_val("resume_b0", req_data, 32'd3);
    tick();
    check_val("resume_b1", req_data, 32'd3);
    tick();
    check_val("resume_b2", req_data, k6[63:32]);

    // Asynchronous reset in the middle of SEND
    #1 rst = 1'b0;
    #1;
    check_val("arst_outputs",
              {cmd_ready, req_valid, rd_ready, result_valid, timeout_err, busy}, 6'd0);
    check_val("arst_req_data", req_data, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_val("arst_cmd_ready_pre", cmd_ready, 0);
    tick();
    check_val("arst_cmd_ready", cmd_ready, 1);
    check_val("arst_no_err", te_count, te_before);
    accept_cmd(3'b111, k5);
    run_send(3'b111, k5);
    do_response(d5, 0, 1);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    // No response at all: timeout after 15 idle cycles
    accept_cmd(3'b001, 64'h5);
    run_send(3'b001, 64'h5);
    repeat (14) tick();
    check_val("to_not_yet", timeout_err, 0);
    check_val("to_rd_ready_still", rd_ready, 1);
    tick();
    check_val("to_pulse", timeout_err, 1);
    check_val("to_rd_ready_low", rd_ready, 0);
    check_val("to_cmd_ready", cmd_ready, 1);
    check_val("to_busy", busy, 0);
    check_val("to_result_clear", result_data, 0);
    check_val("to_result_valid", result_valid, 0);
    tick();
    check_val("to_pulse_end", timeout_err, 0);
    check_val("to_single_pulse", te_count, te_before + 1);

    // Beat arriving exactly on the timeout threshold is captured
    te_before = te_count;
    accept_cmd(3'b110, k6);
    run_send(3'b110, k6);
    do_response(d6, 14, 0);
    check_val("thr_no_err", te_count, te_before);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check_val("thr_cmd_ready", cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
